// File: rtl/counter_fsm_if.sv
// Control interface for counter_fsm.
// The host drives start/flag/wait_timer; the controller returns busy/count_value.
interface counter_fsm_if #(
    parameter int CNT_W   = 8,
    parameter int TIMER_W = 8
);
    logic               start;
    logic               flag;
    logic [TIMER_W-1:0] wait_timer;
    logic               busy;
    logic [CNT_W-1:0]   count_value;

    modport master (
        output start,
        output flag,
        output wait_timer,
        input  busy,
        input  count_value
    );

    modport slave (
        input  start,
        input  flag,
        input  wait_timer,
        output busy,
        output count_value
    );
endinterface

// File: rtl/counter_fsm.sv
// Start-triggered delay-then-count controller.
// Waits wait_timer cycles after start, then counts cycles with flag high.
module counter_fsm #(
    parameter int CNT_W   = 8,
    parameter int TIMER_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    counter_fsm_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] COUNT = 2'd2;

    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

    logic [1:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Next-state logic: accept start in IDLE, run the delay, then count.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    count_d = '0;
                    timer_d = bus.wait_timer;
                    state_d = (bus.wait_timer == '0) ? COUNT : WAIT;
                end
            end
            WAIT: begin
                if (timer_q == TIMER_ONE) begin
                    state_d = COUNT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            COUNT: begin
                // Saturated count ends the run just like flag dropping.
                if (bus.flag && (count_q != CNT_MAX)) begin
                    count_d = count_q + CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // State registers; rst_n is an active-high synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.count_value = count_q;
endmodule

// File: tb/tb_counter_fsm.sv
// Testbench for counter_fsm: directed vector table, reset sequence,
// and randomized stimulus against an operation-level reference model.
module tb_counter_fsm;
    localparam int CNT_W   = 4;
    localparam int TIMER_W = 8;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    counter_fsm_if #(.CNT_W(CNT_W), .TIMER_W(TIMER_W)) bus ();

    counter_fsm #(.CNT_W(CNT_W), .TIMER_W(TIMER_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit rst;
        bit start;
        bit flag;
        int wt;
        bit busy;
        int cnt;
    } vec_t;

    vec_t tbl[$];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: an active run is a pending delay followed by counting.
    bit m_busy = 0;
    int m_left = 0;
    int m_cnt  = 0;
    bit armed  = 0;

    function automatic void add(bit r, bit s, bit f, int wt, bit b, int c);
        vec_t v;
        v.rst = r; v.start = s; v.flag = f; v.wt = wt;
        v.busy = b; v.cnt = c;
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(bit r, bit s, bit f, int wt);
        logic       p_busy;
        logic [CNT_W-1:0] p_cnt;
        bit         acc;
        rst_n          = r;
        bus.start      = s;
        bus.flag       = f;
        bus.wait_timer = wt[TIMER_W-1:0];
        acc    = !r && !m_busy && s;
        p_busy = bus.busy;
        p_cnt  = bus.count_value;
        if (r) begin
            m_busy = 0; m_left = 0; m_cnt = 0;
        end else if (!m_busy) begin
            if (s) begin
                m_busy = 1; m_cnt = 0; m_left = wt;
            end
        end else if (m_left > 0) begin
            m_left--;
        end else if (f && m_cnt < MAXC) begin
            m_cnt++;
        end else begin
            m_busy = 0;
        end
        @(posedge clk);
        #1;
        if (armed || r) begin
            chk("no_x", 32'($isunknown({bus.busy, bus.count_value})), 32'd0);
        end
        if (armed) begin
            if (!p_busy && !acc && !r)
                chk("idle_stable", 32'(bus.count_value), 32'(p_cnt));
            if (bus.count_value < p_cnt)
                chk("no_decrease", 32'((bus.count_value == 0) && (r || acc)), 32'd1);
        end
        chk("model_busy", 32'(bus.busy), 32'(m_busy));
        chk("model_cnt", 32'(bus.count_value), 32'(m_cnt));
        if (r) armed = 1;
    endtask

    initial begin
        // Nominal: wait 3, flag high until edge N+8.
        add(0, 1, 1, 3, 1, 0);
        add(0, 0, 1, 3, 1, 0);
        add(0, 0, 1, 3, 1, 0);
        add(0, 0, 1, 3, 1, 0);
        for (int k = 1; k <= 5; k++) add(0, 0, 1, 3, 1, k);
        add(0, 0, 0, 3, 0, 5);
        add(0, 0, 0, 3, 0, 5);
        // Zero delay: first increment on the edge after acceptance.
        add(0, 1, 1, 0, 1, 0);
        for (int k = 1; k <= 4; k++) add(0, 0, 1, 0, 1, k);
        add(0, 0, 0, 0, 0, 4);
        // Immediate stop: flag low on entering COUNT.
        add(0, 1, 0, 2, 1, 4 - 4);
        add(0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 2, 0, 0);
        // Saturation at 2^CNT_W-1 with no wrap.
        add(0, 1, 1, 1, 1, 0);
        add(0, 0, 1, 1, 1, 0);
        for (int k = 1; k <= MAXC; k++) add(0, 0, 1, 1, 1, k);
        add(0, 0, 1, 1, 0, MAXC);
        add(0, 0, 1, 1, 0, MAXC);
        // Start while busy is ignored; original delay kept.
        add(0, 1, 1, 2, 1, 0);
        add(0, 1, 1, 9, 1, 0);
        add(0, 1, 1, 9, 1, 0);
        add(0, 1, 1, 9, 1, 1);
        add(0, 1, 1, 9, 1, 2);
        add(0, 0, 0, 9, 0, 2);
        // New start in IDLE clears the count.
        add(0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0);

        // Reset state.
        apply(1, 0, 0, 0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_cnt", 32'(bus.count_value), 32'd0);

        // Reset mid-count aborts the run.
        apply(0, 1, 1, 0);
        for (int k = 0; k < 5; k++) apply(0, 0, 1, 0);
        chk("pre_rst_cnt", 32'(bus.count_value), 32'd5);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        apply(1, 0, 1, 0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_cnt", 32'(bus.count_value), 32'd0);
        apply(1, 1, 1, 0);
        chk("midrst2_busy", 32'(bus.busy), 32'd0);
        apply(0, 1, 1, 1);
        chk("post_rst_busy", 32'(bus.busy), 32'd1);
        apply(0, 0, 1, 0);
        apply(0, 0, 1, 0);
        chk("post_rst_cnt", 32'(bus.count_value), 32'd1);
        apply(0, 0, 0, 0);
        chk("post_rst_idle", 32'(bus.busy), 32'd0);

        // Directed table.
        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].start, tbl[i].flag, tbl[i].wt);
            chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_cnt", i), 32'(bus.count_value), 32'(tbl[i].cnt));
        end

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 199) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) != 0,
                  int'($urandom_range(0, 5)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
